// File: rtl/alu_pkg.sv
// Shared constants and payload types for the ALU issue stage: ALU op codes,
// RV32I major opcodes and funct7 encodings.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'b00001;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'b00010;
    localparam logic [OP_W-1:0] ALU_OR    = 5'b00011;
    localparam logic [OP_W-1:0] ALU_AND   = 5'b00100;
    localparam logic [OP_W-1:0] ALU_SLL   = 5'b00101;
    localparam logic [OP_W-1:0] ALU_SRL   = 5'b00110;
    localparam logic [OP_W-1:0] ALU_SRA   = 5'b00111;
    localparam logic [OP_W-1:0] ALU_SLT   = 5'b01000;
    localparam logic [OP_W-1:0] ALU_SLTU  = 5'b01001;
    localparam logic [OP_W-1:0] ALU_ADDI  = 5'b01010;
    localparam logic [OP_W-1:0] ALU_XORI  = 5'b01011;
    localparam logic [OP_W-1:0] ALU_ORI   = 5'b01100;
    localparam logic [OP_W-1:0] ALU_ANDI  = 5'b01101;
    localparam logic [OP_W-1:0] ALU_SLLI  = 5'b01110;
    localparam logic [OP_W-1:0] ALU_SRLI  = 5'b01111;
    // Reserved: SRAI is always issued as ALU_SRA.
    localparam logic [OP_W-1:0] ALU_SRAI  = 5'b10000;
    localparam logic [OP_W-1:0] ALU_SLTI  = 5'b10001;
    localparam logic [OP_W-1:0] ALU_SLTIU = 5'b10010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
        logic              illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle for alu_issue_stage. The forwarding inputs
// exist only when ALU_ISSUE_FWD_EN is defined.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_instr;
    logic [DATA_W-1:0]   in_pc;
    logic [DATA_W-1:0]   in_rs1_data;
    logic [DATA_W-1:0]   in_rs2_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_op;
    logic [REG_W-1:0]    out_rd;
    logic                out_wb_en;
    logic [DATA_W-1:0]   out_pc;
    logic                out_illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic                fwd_valid;
    logic [REG_W-1:0]    fwd_rd;
    logic [DATA_W-1:0]   fwd_data;
`endif

    // Upstream/downstream environment view.
    modport master (
`ifdef ALU_ISSUE_FWD_EN
        output fwd_valid, fwd_rd, fwd_data,
`endif
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_wb_en, out_pc,
               out_illegal
    );

    // Issue stage view.
    modport slave (
`ifdef ALU_ISSUE_FWD_EN
        input  fwd_valid, fwd_rd, fwd_data,
`endif
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_wb_en, out_pc,
               out_illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational RV32I OP / OP-IMM / LUI / AUIPC decoder producing the ALU
// op code and operands; anything else is flagged illegal with zeroed operands.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [REG_W-1:0]  rd,
    output logic              wb_en,
    output logic              illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] shamt;
    logic              unused_rs1_idx;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};
    assign rd     = instr[11:7];
    // Register indices are resolved upstream; only the data is used here.
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        op      = ALU_ADD;
        a       = '0;
        b       = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                a = rs1;
                b = rs2;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  op = ALU_SUB;
                        3'b101:  op = ALU_SRA;
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a = rs1;
                b = imm_i;
                case (funct3)
                    3'b000: op = ALU_ADDI;
                    3'b010: op = ALU_SLTI;
                    3'b011: op = ALU_SLTIU;
                    3'b100: op = ALU_XORI;
                    3'b110: op = ALU_ORI;
                    3'b111: op = ALU_ANDI;
                    3'b001: begin
                        b  = shamt;
                        op = ALU_SLLI;
                        if (funct7 != F7_BASE) illegal = 1'b1;
                    end
                    default: begin
                        b = shamt;
                        if (funct7 == F7_BASE)     op = ALU_SRLI;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                op = ALU_ADDI;
                b  = imm_u;
            end
            OPC_AUIPC: begin
                op = ALU_ADD;
                a  = pc;
                b  = imm_u;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings travel with a clean, inert payload for the trap path.
        if (illegal) begin
            op = ALU_ADD;
            a  = '0;
            b  = '0;
        end
        wb_en = !illegal && (rd != '0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue pipeline register in front of the ALU with valid/ready on both
// sides and flush. Optional operand forwarding under ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);

    logic [XLEN-1:0] rs1_c;
    logic [XLEN-1:0] rs2_c;
    logic            accept_c;
    issue_t          dec_c;
    issue_t          held_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;

`ifdef ALU_ISSUE_FWD_EN
    // Bypass a just-produced result over the stale register-file read.
    always_comb begin
        rs1_c = bus.in_rs1_data;
        rs2_c = bus.in_rs2_data;
        if (bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_instr[19:15]))
            rs1_c = bus.fwd_data;
        if (bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_instr[24:20]))
            rs2_c = bus.fwd_data;
    end
`else
    assign rs1_c = bus.in_rs1_data;
    assign rs2_c = bus.in_rs2_data;
`endif

    alu_decoder u_dec (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .rs1     (rs1_c),
        .rs2     (rs2_c),
        .op      (dec_c.op),
        .a       (dec_c.a),
        .b       (dec_c.b),
        .rd      (dec_c.rd),
        .wb_en   (dec_c.wb_en),
        .illegal (dec_c.illegal)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Flush beats accept and stall; a stalled payload otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            held_q  <= '0;
            pc_q    <= RESET_PC;
        end else if (bus.flush) begin
            valid_q      <= 1'b0;
            held_q.wb_en <= 1'b0;
        end else if (accept_c) begin
            valid_q <= 1'b1;
            held_q  <= dec_c;
            pc_q    <= bus.in_pc;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.alu_op      = held_q.op;
    assign bus.alu_a       = held_q.a;
    assign bus.alu_b       = held_q.b;
    assign bus.out_rd      = held_q.rd;
    assign bus.out_wb_en   = held_q.wb_en;
    assign bus.out_illegal = held_q.illegal;
    assign bus.out_pc      = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected
// payloads; a negedge monitor pops and compares on every handshake.
module tb_alu_issue_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    alu_issue_stage_if bus();

    alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic wb, input logic [31:0] pc,
                                input logic ill);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.wb = wb; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
    endtask

    // Present an instruction, wait (bounded) for acceptance, record expectation.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        int n = 0;
        drive(instr, pc, rs1, rs2);
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready stayed %b for pc %h", bus.in_ready, pc);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: pc %h op %h with no expectation", bus.out_pc, bus.alu_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("op",      32'(bus.alu_op),      32'(e.op));
                chk("alu_a",   bus.alu_a,            e.a);
                chk("alu_b",   bus.alu_b,            e.b);
                chk("rd",      32'(bus.out_rd),      32'(e.rd));
                chk("wb_en",   32'(bus.out_wb_en),   32'(e.wb));
                chk("pc",      bus.out_pc,           e.pc);
                chk("illegal", 32'(bus.out_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.in_rs1_data = '0; bus.in_rs2_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
        bus.fwd_valid = 1'b0; bus.fwd_rd = '0; bus.fwd_data = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc",    bus.out_pc,         RST_PC);
        chk("rst_a",     bus.alu_a,          32'd0);
        chk("rst_wb",    32'(bus.out_wb_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Decode coverage, back-to-back with out_ready=1.
        issue(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(5'b00000, 32'd5, 32'd7, 5'd3, 1'b1, 32'h100, 1'b0));
        issue(32'h40435293, 32'h104, 32'h8000_0000, 32'd1,
              mk(5'b00111, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 32'h104, 1'b0));
        issue(32'hFFF0B093, 32'h108, 32'd3, 32'd0,
              mk(5'b10010, 32'd3, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h108, 1'b0));
        issue(32'h40208233, 32'h10C, 32'd9, 32'd4, mk(5'b00001, 32'd9, 32'd4, 5'd4, 1'b1, 32'h10C, 1'b0));
        issue(32'h123453B7, 32'h110, 32'hDEAD, 32'hBEEF,
              mk(5'b01010, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 32'h110, 1'b0));
        issue(32'hABCDE417, 32'h2000, 32'd1, 32'd2,
              mk(5'b00000, 32'h2000, 32'hABCD_E000, 5'd8, 1'b1, 32'h2000, 1'b0));
        issue(32'h000000F3, 32'h118, 32'd6, 32'd6, mk(5'b00000, 32'd0, 32'd0, 5'd1, 1'b0, 32'h118, 1'b1));
        issue(32'h00508013, 32'h11C, 32'd20, 32'd0, mk(5'b01010, 32'd20, 32'd5, 5'd0, 1'b0, 32'h11C, 1'b0));
        issue(32'h40009093, 32'h120, 32'd8, 32'd8, mk(5'b00000, 32'd0, 32'd0, 5'd1, 1'b0, 32'h120, 1'b1));
        issue(32'h02208233, 32'h124, 32'd8, 32'd8, mk(5'b00000, 32'd0, 32'd0, 5'd4, 1'b0, 32'h124, 1'b1));
        issue(32'hFF01F113, 32'h128, 32'h55, 32'd0,
              mk(5'b01101, 32'h55, 32'hFFFF_FFF0, 5'd2, 1'b1, 32'h128, 1'b0));
        issue(32'h0020D2B3, 32'h12C, 32'hF0, 32'd4, mk(5'b00110, 32'hF0, 32'd4, 5'd5, 1'b1, 32'h12C, 1'b0));
        idle(3);

        // Backpressure: hold XOR for 3 cycles with OR waiting, then back-to-back.
        bus.out_ready = 1'b0;
        issue(32'h0020C4B3, 32'h200, 32'h11, 32'h22, mk(5'b00010, 32'h11, 32'h22, 5'd9, 1'b1, 32'h200, 1'b0));
        drive(32'h0020E533, 32'h204, 32'h33, 32'h44);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
            chk("stall_a",        bus.alu_a,          32'h11);
            chk("stall_op",       32'(bus.alu_op),    32'(5'b00010));
            chk("stall_pc",       bus.out_pc,         32'h200);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(mk(5'b00011, 32'h33, 32'h44, 5'd10, 1'b1, 32'h204, 1'b0));
        @(posedge clk); #1;
        idle(3);

        // Flush while stalled with a new instruction waiting: both vanish.
        bus.out_ready = 1'b0;
        issue(32'h0020F5B3, 32'h300, 32'h1, 32'h2, mk(5'b00100, 32'h1, 32'h2, 5'd11, 1'b1, 32'h300, 1'b0));
        drive(32'h00209633, 32'h304, 32'h3, 32'h4);
        bus.flush = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_stall_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_stall_wb",    32'(bus.out_wb_en), 32'd0);
        bus.out_ready = 1'b1;
        idle(3);

        // Flush against an accept on an empty stage drops the incoming op.
        drive(32'h0020B6B3, 32'h400, 32'h5, 32'h6);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_accept_valid", 32'(bus.out_valid), 32'd0);
        idle(3);

`ifdef ALU_ISSUE_FWD_EN
        bus.fwd_valid = 1'b1; bus.fwd_rd = 5'd1; bus.fwd_data = 32'd99;
        issue(32'h002081B3, 32'h500, 32'd5, 32'd7, mk(5'b00000, 32'd99, 32'd7, 5'd3, 1'b1, 32'h500, 1'b0));
        bus.fwd_rd = 5'd2;
        issue(32'h002081B3, 32'h504, 32'd5, 32'd7, mk(5'b00000, 32'd5, 32'd99, 5'd3, 1'b1, 32'h504, 1'b0));
        bus.fwd_rd = 5'd0;
        issue(32'h002001B3, 32'h508, 32'd11, 32'd7, mk(5'b00000, 32'd11, 32'd7, 5'd3, 1'b1, 32'h508, 1'b0));
        bus.fwd_valid = 1'b0;
        idle(3);
`endif

        // Asynchronous reset in the middle of a stall.
        bus.out_ready = 1'b0;
        issue(32'h07F0E713, 32'h600, 32'h100, 32'h0, mk(5'b01100, 32'h100, 32'h7F, 5'd14, 1'b1, 32'h600, 1'b0));
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("arst_valid",   32'(bus.out_valid),   32'd0);
        chk("arst_a",       bus.alu_a,            32'd0);
        chk("arst_b",       bus.alu_b,            32'd0);
        chk("arst_op",      32'(bus.alu_op),      32'd0);
        chk("arst_rd",      32'(bus.out_rd),      32'd0);
        chk("arst_wb",      32'(bus.out_wb_en),   32'd0);
        chk("arst_illegal", 32'(bus.out_illegal), 32'd0);
        chk("arst_pc",      bus.out_pc,           RST_PC);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        idle(4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
